cache_mem_arbiter: RTL and testbench
====================================

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte address width on all ports.
REQ-002 Parameter LINE_WIDTH, default 128, line-transfer data width on all ports.
REQ-003 clk input 1: clock; all state changes on rising edge.
REQ-004 rstn input 1: reset, asynchronous, active-low.
REQ-005 pN_mem_r / pN_mem_w (N=0,1) input 1 each: port N line read / line write request, level held until pN_mem_ready.
REQ-006 pN_mem_addr input ADDR_WIDTH; pN_mem_w_data input LINE_WIDTH: port N request address and write line.
REQ-007 pN_mem_r_data output LINE_WIDTH; pN_mem_ready output 1: returned line and completion strobe to port N.
REQ-008 m_req, m_we output 1 each: downstream memory request and write select (1 = write).
REQ-009 m_addr output ADDR_WIDTH; m_wdata output LINE_WIDTH: downstream address and write line.
REQ-010 m_rdata input LINE_WIDTH; m_ready input 1: downstream returned line and completion.
REQ-011 busy output 1 (transaction outstanding); owner output 1 (granted port, valid when busy=1).

Function
REQ-012 FSM states: IDLE, BUSY, TURN; encoding from the shared package.
REQ-013 IDLE: no port requesting -> stay in IDLE; otherwise pick a winner (REQ-020/021), latch its addr, w_data, op (w = write, r = read) and index into owner/addr/data/op registers, -> BUSY.
REQ-014 Port with both mem_r and mem_w high: treated as a write for that grant.
REQ-015 BUSY: m_req=1; m_we, m_addr, m_wdata from the latched registers only, never from live port inputs.
REQ-016 BUSY with m_ready=1: pOwner_mem_ready=1 combinationally in that same cycle, pOwner_mem_r_data=m_rdata, -> TURN.
REQ-017 TURN: one dead cycle, m_req=0, no grant, -> IDLE; gives the requester one cycle to drop or change its request.
REQ-018 Non-owner pN_mem_ready is 0 at all times; pN_mem_r_data is m_rdata when N is the owner, else 0.
REQ-019 Minimum request-to-ready latency: 2 cycles (IDLE grant, BUSY with m_ready=1); a port's successive grants are at least 3 cycles apart.
REQ-020 Single requester in IDLE: granted immediately, regardless of priority state.
REQ-021 Both ports requesting in IDLE: winner chosen per REQ-026/027.
REQ-022 A request deasserted while BUSY does not abort the transaction; completion still follows the m_ready handshake.
REQ-023 busy=1 in BUSY and TURN; owner holds its value until the next grant.

Reset
REQ-024 rstn low: FSM -> IDLE; m_req=0, m_we=0, m_addr=0, m_wdata=0, pN_mem_ready=0, pN_mem_r_data=0, busy=0, owner=0, latched regs=0, priority pointer=0 (port 0 first).
REQ-025 Reset during BUSY abandons the downstream transaction with no ready returned; the first grant after release follows REQ-013.

Configuration
REQ-026 Macro CACHE_ARB_RR_EN defined: round-robin; 1-bit pointer names the preferred port and is set to the non-winner after every grant.
REQ-027 CACHE_ARB_RR_EN undefined: fixed priority, port 0 always wins a tie; no pointer register.

Structure
REQ-028 Package cache_arb_pkg holds the FSM state typedef/encoding and the default ADDR_WIDTH/LINE_WIDTH constants.
REQ-029 Sub-module arb_pick2: combinational 2-way picker (inputs: two request bits, pointer; output: winner index); instantiated once.

Verification
REQ-030 p0_mem_r=1, addr 0x0000_0040; m_ready 3 cycles after m_req -> m_addr=0x40, m_we=0; p0_mem_ready pulses exactly 1 cycle with p0_mem_r_data=m_rdata; p1_mem_ready stays 0.
REQ-031 p0_mem_w and p1_mem_r high same cycle, RR build -> port 0 served first, then port 1 granted in the IDLE after TURN; second tie -> port 1 first.
REQ-032 Same tie, fixed-priority build, both held continuously -> port 0 wins every grant; port 1 never granted (starvation expected).
REQ-033 p1 writeback 0x0000_1230 (line 0xA5..A5) then p1 read 0x0000_2000 immediately after its ready -> two downstream transactions in order, m_we=1 then 0, TURN cycle between them.
REQ-034 Change p0_mem_addr to 0x80 while BUSY -> m_addr stays at the latched 0x40 until m_ready.
REQ-035 rstn low mid-BUSY -> all outputs 0 asynchronously; after release, a fresh p1 request is granted normally.

Source files
------------

// File: rtl/cache_arb_pkg.sv
// Shared definitions for the two-port cache line arbiter: FSM encoding and default widths.
`timescale 1ns/1ps
package cache_arb_pkg;

    localparam int ADDR_WIDTH_DEF = 32;
    localparam int LINE_WIDTH_DEF = 128;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE = 2'd0;
    localparam arb_state_t ST_BUSY = 2'd1;
    localparam arb_state_t ST_TURN = 2'd2;

endpackage

// File: rtl/arb_pick2.sv
// Combinational two-way picker: a lone requester always wins, a tie goes to the port named by ptr.
`timescale 1ns/1ps
module arb_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic ptr,
    output logic win
);

    assign win = req1 & (~req0 | ptr);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Two-port cache-to-memory line arbiter with IDLE/BUSY/TURN sequencing.
// Define CACHE_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 wins every tie.
`timescale 1ns/1ps
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int LINE_WIDTH = LINE_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  p0_mem_r,
    input  logic                  p0_mem_w,
    input  logic [ADDR_WIDTH-1:0] p0_mem_addr,
    input  logic [LINE_WIDTH-1:0] p0_mem_w_data,
    output logic [LINE_WIDTH-1:0] p0_mem_r_data,
    output logic                  p0_mem_ready,
    input  logic                  p1_mem_r,
    input  logic                  p1_mem_w,
    input  logic [ADDR_WIDTH-1:0] p1_mem_addr,
    input  logic [LINE_WIDTH-1:0] p1_mem_w_data,
    output logic [LINE_WIDTH-1:0] p1_mem_r_data,
    output logic                  p1_mem_ready,
    output logic                  m_req,
    output logic                  m_we,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [LINE_WIDTH-1:0] m_wdata,
    input  logic [LINE_WIDTH-1:0] m_rdata,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  owner
);

    arb_state_t            state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;

    logic req0, req1, pick_ptr, pick_win;
    logic in_busy, done;

    assign req0 = p0_mem_r | p0_mem_w;
    assign req1 = p1_mem_r | p1_mem_w;

`ifdef CACHE_ARB_RR_EN
    logic ptr_q, ptr_d;
    assign pick_ptr = ptr_q;
`else
    assign pick_ptr = 1'b0;
`endif

    arb_pick2 u_pick (
        .req0 (req0),
        .req1 (req1),
        .ptr  (pick_ptr),
        .win  (pick_win)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef CACHE_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    // A port raising both read and write is served as a write.
                    owner_d = pick_win;
                    we_d    = pick_win ? p1_mem_w      : p0_mem_w;
                    addr_d  = pick_win ? p1_mem_addr   : p0_mem_addr;
                    wdata_d = pick_win ? p1_mem_w_data : p0_mem_w_data;
`ifdef CACHE_ARB_RR_EN
                    ptr_d   = ~pick_win;
`endif
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (m_ready) begin
                    state_d = ST_TURN;
                end
            end
            ST_TURN: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef CACHE_ARB_RR_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Downstream sees only the latched request, and only while the transaction is live.
    assign in_busy = (state_q == ST_BUSY);
    assign done    = in_busy & m_ready;

    assign m_req   = in_busy;
    assign m_we    = in_busy & we_q;
    assign m_addr  = in_busy ? addr_q  : '0;
    assign m_wdata = in_busy ? wdata_q : '0;

    assign busy  = (state_q != ST_IDLE);
    assign owner = owner_q;

    assign p0_mem_ready  = done & ~owner_q;
    assign p1_mem_ready  = done &  owner_q;
    assign p0_mem_r_data = (busy && !owner_q) ? m_rdata : '0;
    assign p1_mem_r_data = (busy &&  owner_q) ? m_rdata : '0;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: vector table, directed corner sequences, randomized run vs. a transaction-level model.
`timescale 1ns/1ps
module tb_cache_mem_arbiter;

    logic         clk = 1'b0;
    logic         rstn;
    logic         p0_mem_r, p0_mem_w, p1_mem_r, p1_mem_w;
    logic [31:0]  p0_mem_addr, p1_mem_addr;
    logic [127:0] p0_mem_w_data, p1_mem_w_data;
    logic [127:0] p0_mem_r_data, p1_mem_r_data;
    logic         p0_mem_ready, p1_mem_ready;
    logic         m_req, m_we;
    logic [31:0]  m_addr;
    logic [127:0] m_wdata, m_rdata;
    logic         m_ready;
    logic         busy, owner;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter dut (
        .clk           (clk),
        .rstn          (rstn),
        .p0_mem_r      (p0_mem_r),
        .p0_mem_w      (p0_mem_w),
        .p0_mem_addr   (p0_mem_addr),
        .p0_mem_w_data (p0_mem_w_data),
        .p0_mem_r_data (p0_mem_r_data),
        .p0_mem_ready  (p0_mem_ready),
        .p1_mem_r      (p1_mem_r),
        .p1_mem_w      (p1_mem_w),
        .p1_mem_addr   (p1_mem_addr),
        .p1_mem_w_data (p1_mem_w_data),
        .p1_mem_r_data (p1_mem_r_data),
        .p1_mem_ready  (p1_mem_ready),
        .m_req         (m_req),
        .m_we          (m_we),
        .m_addr        (m_addr),
        .m_wdata       (m_wdata),
        .m_rdata       (m_rdata),
        .m_ready       (m_ready),
        .busy          (busy),
        .owner         (owner)
    );

    typedef struct {
        logic [1:0]   op0;   // {w, r}
        logic [1:0]   op1;
        logic [31:0]  a0;
        logic [31:0]  a1;
        logic [127:0] d0;
        logic [127:0] d1;
        logic         eown;
        logic         ewe;
        logic [31:0]  eaddr;
        logic [127:0] edata;
    } vec_t;

    vec_t vecs[6];

    // transaction-level reference model state
    bit           mh;     // downstream transaction outstanding
    bit           md;     // dead cycle pending after completion
    logic         mo, mwe;
    logic [31:0]  ma;
    logic [127:0] mdat;
`ifdef CACHE_ARB_RR_EN
    logic         mptr;
`endif

    task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [127:0] r128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        p0_mem_r = 0; p0_mem_w = 0; p1_mem_r = 0; p1_mem_w = 0;
        m_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn = 0;
        nxt(); nxt();
        rstn = 1;
        mh = 0; md = 0; mo = 0; mwe = 0; ma = '0; mdat = '0;
`ifdef CACHE_ARB_RR_EN
        mptr = 0;
`endif
    endtask

    task automatic model_step();
        logic q0, q1, w, tie;
        q0 = p0_mem_r | p0_mem_w;
        q1 = p1_mem_r | p1_mem_w;
`ifdef CACHE_ARB_RR_EN
        tie = mptr;
`else
        tie = 1'b0;
`endif
        if (mh) begin
            if (m_ready) begin mh = 0; md = 1; end
        end else if (md) begin
            md = 0;
        end else if (q0 || q1) begin
            w    = (q0 && q1) ? tie : q1;
            mo   = w;
            mwe  = w ? p1_mem_w : p0_mem_w;
            ma   = w ? p1_mem_addr : p0_mem_addr;
            mdat = w ? p1_mem_w_data : p0_mem_w_data;
            mh   = 1;
`ifdef CACHE_ARB_RR_EN
            mptr = ~w;
`endif
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] rd;
        logic [127:0] line_a5, line_11, line_77, line_3c;
        logic         exp_own;
        logic         e0, e1;

        line_a5 = {4{32'hA5A5_A5A5}};
        line_11 = {4{32'h1111_1111}};
        line_77 = {4{32'h7777_7777}};
        line_3c = {4{32'h3C3C_3C3C}};
        p0_mem_addr = '0; p1_mem_addr = '0;
        p0_mem_w_data = '0; p1_mem_w_data = '0;
        m_rdata = '0;

        // ---- reset values, with inputs active to catch leakage ----
        idle_inputs();
        rstn = 0;
        p0_mem_r = 1; p1_mem_w = 1; m_ready = 1; m_rdata = line_3c;
        #3;
        chk("reset_outputs",
            {m_req, m_we, m_addr, m_wdata, p0_mem_ready, p1_mem_ready, p0_mem_r_data, p1_mem_r_data, busy, owner}, '0);
        nxt();
        chk("reset_held_outputs", {m_req, m_we, m_addr, m_wdata, p0_mem_ready, p1_mem_ready, busy, owner}, '0);
        do_reset();

        // ---- vector table ----
        vecs[0] = '{2'b01, 2'b00, 32'h0000_0040, 32'h0, line_11, '0,       1'b0, 1'b0, 32'h0000_0040, line_11};
        vecs[1] = '{2'b00, 2'b10, 32'h0, 32'h0000_1230, '0, line_a5,       1'b1, 1'b1, 32'h0000_1230, line_a5};
        vecs[2] = '{2'b11, 2'b00, 32'h0000_0100, 32'h0, line_77, '0,       1'b0, 1'b1, 32'h0000_0100, line_77};
`ifdef CACHE_ARB_RR_EN
        vecs[3] = '{2'b01, 2'b10, 32'h0000_0200, 32'h0000_0300, line_11, line_a5, 1'b1, 1'b1, 32'h0000_0300, line_a5};
`else
        vecs[3] = '{2'b01, 2'b10, 32'h0000_0200, 32'h0000_0300, line_11, line_a5, 1'b0, 1'b0, 32'h0000_0200, line_11};
`endif
        vecs[4] = '{2'b10, 2'b01, 32'h0000_0400, 32'h0000_0500, line_3c, line_77, 1'b0, 1'b1, 32'h0000_0400, line_3c};
        vecs[5] = '{2'b00, 2'b01, 32'h0, 32'hFFFF_FFC0, '0, line_77,       1'b1, 1'b0, 32'hFFFF_FFC0, line_77};

        for (int i = 0; i < 6; i++) begin
            nxt();
            {p0_mem_w, p0_mem_r} = vecs[i].op0;
            {p1_mem_w, p1_mem_r} = vecs[i].op1;
            p0_mem_addr = vecs[i].a0; p1_mem_addr = vecs[i].a1;
            p0_mem_w_data = vecs[i].d0; p1_mem_w_data = vecs[i].d1;
            m_ready = 0;
            nxt();
            settle();
            chk($sformatf("vec%0d_grant", i), {m_req, busy, owner, m_we},
                {1'b1, 1'b1, vecs[i].eown, vecs[i].ewe});
            chk($sformatf("vec%0d_addr", i), m_addr, vecs[i].eaddr);
            chk($sformatf("vec%0d_wdata", i), m_wdata, vecs[i].edata);
            rd = r128();
            m_ready = 1; m_rdata = rd;
            #1;
            chk($sformatf("vec%0d_ready", i), {p1_mem_ready, p0_mem_ready},
                vecs[i].eown ? 2'b10 : 2'b01);
            chk($sformatf("vec%0d_rdata", i), vecs[i].eown ? p1_mem_r_data : p0_mem_r_data, rd);
            chk($sformatf("vec%0d_other_rdata", i), vecs[i].eown ? p0_mem_r_data : p1_mem_r_data, '0);
            nxt();
            idle_inputs();
            settle();
            chk($sformatf("vec%0d_turn", i), {m_req, busy, p0_mem_ready, p1_mem_ready}, 4'b0100);
            nxt();
            settle();
            chk($sformatf("vec%0d_idle", i), {m_req, busy}, 2'b00);
        end

        // ---- p0 read, m_ready 3 cycles after m_req, address changed while BUSY ----
        do_reset();
        p0_mem_r = 1; p0_mem_addr = 32'h0000_0040;
        nxt();
        chk("rd40_req", {m_req, m_we, m_addr}, {1'b1, 1'b0, 32'h0000_0040});
        p0_mem_addr = 32'h0000_0080;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("rd40_hold_addr", m_addr, 32'h0000_0040);
            chk("rd40_no_ready", {p0_mem_ready, p1_mem_ready, m_req}, 3'b001);
            nxt();
        end
        rd = r128();
        m_ready = 1; m_rdata = rd;
        #1;
        chk("rd40_ready", {p0_mem_ready, p1_mem_ready, m_addr}, {2'b10, 32'h0000_0040});
        chk("rd40_rdata", p0_mem_r_data, rd);
        nxt();
        idle_inputs();
        m_ready = 1;
        #1;
        chk("rd40_ready_pulse", {p0_mem_ready, p1_mem_ready}, 2'b00);
        m_ready = 0;
        nxt();

        // ---- p1 writeback then read right after its ready ----
        nxt();
        p1_mem_w = 1; p1_mem_addr = 32'h0000_1230; p1_mem_w_data = line_a5;
        nxt();
        chk("wb_req", {m_req, m_we, owner, m_addr}, {1'b1, 1'b1, 1'b1, 32'h0000_1230});
        chk("wb_data", m_wdata, line_a5);
        m_ready = 1;
        #1;
        chk("wb_ready", p1_mem_ready, 1'b1);
        nxt();
        m_ready = 0;
        p1_mem_w = 0; p1_mem_r = 1; p1_mem_addr = 32'h0000_2000;
        #1;
        chk("wb_turn", {m_req, busy}, 2'b01);
        nxt();
        chk("wb_idle", {m_req, busy}, 2'b00);
        nxt();
        chk("rd2000_req", {m_req, m_we, owner, m_addr}, {1'b1, 1'b0, 1'b1, 32'h0000_2000});
        m_ready = 1;
        #1;
        chk("rd2000_ready", p1_mem_ready, 1'b1);
        nxt();
        idle_inputs();

        // ---- tie held continuously ----
        do_reset();
        p0_mem_w = 1; p0_mem_addr = 32'h0000_0600; p0_mem_w_data = line_11;
        p1_mem_r = 1; p1_mem_addr = 32'h0000_0700;
        for (int k = 0; k < 4; k++) begin
`ifdef CACHE_ARB_RR_EN
            exp_own = k[0];
`else
            exp_own = 1'b0;
`endif
            for (int t = 0; t < 6 && !m_req; t++) nxt();
            chk("tie_grant_seen", m_req, 1'b1);
            chk($sformatf("tie_owner%0d", k), owner, exp_own);
            m_ready = 1;
            nxt();
            m_ready = 0;
        end
        idle_inputs();

        // ---- asynchronous reset mid-BUSY, then a fresh p1 request ----
        nxt(); nxt();
        p0_mem_r = 1; p0_mem_addr = 32'h0000_0040;
        nxt();
        m_ready = 1; m_rdata = line_3c;
        #2;
        chk("arst_pre", {m_req, p0_mem_ready}, 2'b11);
        rstn = 0;
        #1;
        chk("arst_outputs",
            {m_req, m_we, m_addr, m_wdata, p0_mem_ready, p1_mem_ready, p0_mem_r_data, p1_mem_r_data, busy, owner}, '0);
        nxt();
        rstn = 1;
        idle_inputs();
        p1_mem_r = 1; p1_mem_addr = 32'h0000_0500;
        nxt();
        chk("arst_regrant", {m_req, owner, m_we, m_addr}, {1'b1, 1'b1, 1'b0, 32'h0000_0500});
        m_ready = 1;
        #1;
        chk("arst_regrant_ready", {p0_mem_ready, p1_mem_ready}, 2'b01);
        nxt();

        // ---- randomized run against the model ----
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            nxt();
            p0_mem_r = ($urandom_range(0, 2) == 0);
            p0_mem_w = ($urandom_range(0, 3) == 0);
            p1_mem_r = ($urandom_range(0, 2) == 0);
            p1_mem_w = ($urandom_range(0, 3) == 0);
            p0_mem_addr = $urandom; p1_mem_addr = $urandom;
            p0_mem_w_data = r128(); p1_mem_w_data = r128();
            m_ready = ($urandom_range(0, 2) == 0);
            m_rdata = r128();
            settle();
            e0 = mh && m_ready && !mo;
            e1 = mh && m_ready && mo;
            chk("rnd_ctrl", {m_req, p0_mem_ready, p1_mem_ready, busy, owner},
                {mh, e0, e1, (mh || md), mo});
            if (mh) chk("rnd_payload", {m_we, m_addr, m_wdata}, {mwe, ma, mdat});
            if (mo) begin
                chk("rnd_p0_rdata_zero", p0_mem_r_data, '0);
                if (mh || md) chk("rnd_p1_rdata", p1_mem_r_data, m_rdata);
            end else begin
                chk("rnd_p1_rdata_zero", p1_mem_r_data, '0);
                if (mh || md) chk("rnd_p0_rdata", p0_mem_r_data, m_rdata);
            end
            model_step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
